// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: FSM encoding, the
// predictor init value and the PC -> index/tag slice helpers.
package btb_pkg;

    // Widest PC the slice helpers accept; callers zero-extend into this.
    localparam int PC_MAX_W = 64;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } btb_state_e;

    // Counter state written into every entry when the table is swept.
    localparam logic [1:0] CTR_WEAK_NT = 2'b01;

    // Table index: PC bits [idx_w+1:2] (word-aligned PCs).
    function automatic logic [PC_MAX_W-1:0] btb_idx(input logic [PC_MAX_W-1:0] pc,
                                                     input int idx_w);
        return (pc >> 2) & ((PC_MAX_W'(1) << idx_w) - PC_MAX_W'(1));
    endfunction

    // Tag: every PC bit above the index field.
    function automatic logic [PC_MAX_W-1:0] btb_tag(input logic [PC_MAX_W-1:0] pc,
                                                     input int idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/btb_sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module btb_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next value: increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/btb_ctrl.sv
// Direct-mapped branch target buffer with sweep/run controller and
// lookup/hit statistics. Lookups are combinational off the stored table;
// updates and sweep writes land on the clock edge (no forwarding).
module btb_ctrl
    import btb_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             LookupValid,
    input  logic [PC_W-1:0]  LookupPc,
    output logic             PcMatchValid,
    output logic [PC_W-1:0]  PredTarget,
    output logic [1:0]       CtrlIn,
    input  logic             WriteEnable,
    input  logic [PC_W-1:0]  UpdPc,
    input  logic [PC_W-1:0]  UpdTarget,
    input  logic [1:0]       CtrlOut,
    input  logic             ClearReq,
    output logic             Busy,
    output logic [CNT_W-1:0] LookupCnt,
    output logic [CNT_W-1:0] HitCnt
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int TAG_W = PC_W - IDX_W - 2;

    btb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Table storage: no reset, the sweep defines the contents.
    logic             valid_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem   [DEPTH];
    logic [PC_W-1:0]  tgt_mem   [DEPTH];
    logic [1:0]       ctr_mem   [DEPTH];

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_valid;
    logic [TAG_W-1:0] wr_tag;
    logic [PC_W-1:0]  wr_tgt;
    logic [1:0]       wr_ctr;

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             run;

    assign lk_idx  = IDX_W'(btb_idx(PC_MAX_W'(LookupPc), IDX_W));
    assign lk_tag  = TAG_W'(btb_tag(PC_MAX_W'(LookupPc), IDX_W));
    assign upd_idx = IDX_W'(btb_idx(PC_MAX_W'(UpdPc), IDX_W));
    assign upd_tag = TAG_W'(btb_tag(PC_MAX_W'(UpdPc), IDX_W));
    assign run     = (state_q == ST_RUN);

    // Next state: sweep all entries once, then run until a clear request.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_SWEEP: begin
                ptr_d = ptr_q + IDX_W'(1);
                if (ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ClearReq) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = ST_SWEEP;
                ptr_d   = '0;
            end
        endcase
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SWEEP;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Single write port: sweep invalidation has priority; a clear request
    // in the same cycle as an update drops the update.
    always_comb begin
        wr_en    = 1'b0;
        wr_idx   = ptr_q;
        wr_valid = 1'b0;
        wr_tag   = '0;
        wr_tgt   = '0;
        wr_ctr   = CTR_WEAK_NT;
        if (!run) begin
            wr_en = 1'b1;
        end else if (WriteEnable && !ClearReq) begin
            wr_en    = 1'b1;
            wr_idx   = upd_idx;
            wr_valid = 1'b1;
            wr_tag   = upd_tag;
            wr_tgt   = UpdTarget;
            wr_ctr   = CtrlOut;
        end
    end

    // Table write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            valid_mem[wr_idx] <= wr_valid;
            tag_mem[wr_idx]   <= wr_tag;
            tgt_mem[wr_idx]   <= wr_tgt;
            ctr_mem[wr_idx]   <= wr_ctr;
        end
    end

    // Zero-latency lookup; outputs forced to zero on miss.
    always_comb begin
        PcMatchValid = LookupValid && run && valid_mem[lk_idx]
                       && (tag_mem[lk_idx] == lk_tag);
        PredTarget   = PcMatchValid ? tgt_mem[lk_idx] : '0;
        CtrlIn       = PcMatchValid ? ctr_mem[lk_idx] : 2'b00;
    end

    assign Busy = !run;

    btb_sat_cnt #(.CNT_W(CNT_W)) u_lookup_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (LookupValid && run),
        .count (LookupCnt)
    );

    btb_sat_cnt #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (PcMatchValid),
        .count (HitCnt)
    );

endmodule

// File: tb/tb_btb_ctrl.sv
// Directed bench for btb_ctrl: lookup expectations go into a scoreboard
// queue; a monitor pops and compares whenever a lookup is presented.
module tb_btb_ctrl;

    localparam int PC_W  = 32;
    localparam int IDX_W = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             LookupValid;
    logic [PC_W-1:0]  LookupPc;
    logic             PcMatchValid;
    logic [PC_W-1:0]  PredTarget;
    logic [1:0]       CtrlIn;
    logic             WriteEnable;
    logic [PC_W-1:0]  UpdPc;
    logic [PC_W-1:0]  UpdTarget;
    logic [1:0]       CtrlOut;
    logic             ClearReq;
    logic             Busy;
    logic [CNT_W-1:0] LookupCnt;
    logic [CNT_W-1:0] HitCnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic            hit;
        logic [PC_W-1:0] tgt;
        logic [1:0]      ctr;
        string           name;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    btb_ctrl #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .LookupValid  (LookupValid),
        .LookupPc     (LookupPc),
        .PcMatchValid (PcMatchValid),
        .PredTarget   (PredTarget),
        .CtrlIn       (CtrlIn),
        .WriteEnable  (WriteEnable),
        .UpdPc        (UpdPc),
        .UpdTarget    (UpdTarget),
        .CtrlOut      (CtrlOut),
        .ClearReq     (ClearReq),
        .Busy         (Busy),
        .LookupCnt    (LookupCnt),
        .HitCnt       (HitCnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic lookup(input logic [PC_W-1:0] pc, input logic h,
                          input logic [PC_W-1:0] t, input logic [1:0] c,
                          input string name);
        exp_t e;
        LookupValid = 1'b1;
        LookupPc    = pc;
        e.hit = h; e.tgt = t; e.ctr = c; e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic update(input logic [PC_W-1:0] pc, input logic [PC_W-1:0] t,
                          input logic [1:0] c);
        WriteEnable = 1'b1;
        UpdPc       = pc;
        UpdTarget   = t;
        CtrlOut     = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        LookupValid = 1'b0;
        WriteEnable = 1'b0;
        ClearReq    = 1'b0;
    endtask

    // Monitor: compare every presented lookup against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (LookupValid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL lookup_unexpected: pc 0x%0h with empty scoreboard", LookupPc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (PcMatchValid !== e.hit || PredTarget !== e.tgt || CtrlIn !== e.ctr) begin
                        errors++;
                        $display("FAIL %s: pc 0x%0h got hit=%0b tgt=0x%0h ctr=%0b expected hit=%0b tgt=0x%0h ctr=%0b",
                                 e.name, LookupPc, PcMatchValid, PredTarget, CtrlIn,
                                 e.hit, e.tgt, e.ctr);
                    end else begin
                        $display("ok   %s: pc 0x%0h hit=%0b tgt=0x%0h ctr=%0b",
                                 e.name, LookupPc, PcMatchValid, PredTarget, CtrlIn);
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int n;
        rst_n = 1'b0;
        LookupValid = 1'b0; LookupPc = '0;
        WriteEnable = 1'b0; UpdPc = '0; UpdTarget = '0; CtrlOut = 2'b00;
        ClearReq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(Busy), 32'd1);
        chk("reset_lookupcnt", 32'(LookupCnt), 32'd0);
        chk("reset_hitcnt", 32'(HitCnt), 32'd0);
        rst_n = 1'b1;

        // Initial sweep length.
        n = 0;
        while (Busy && n < 100) begin step(); n++; end
        chk("init_sweep_cycles", 32'(n), 32'd16);

        lookup(32'h40, 1'b0, 32'h0, 2'b00, "cold_miss_40"); step();
        update(32'h40, 32'h100, 2'b10); step();
        lookup(32'h40, 1'b1, 32'h100, 2'b10, "hit_40"); step();
        // Same-cycle update: old contents seen this cycle, new next cycle.
        update(32'h40, 32'h100, 2'b11);
        lookup(32'h40, 1'b1, 32'h100, 2'b10, "sameCycle_old_40"); step();
        lookup(32'h40, 1'b1, 32'h100, 2'b11, "sameCycle_new_40"); step();
        // Aliasing on idx 0.
        update(32'h80, 32'h200, 2'b01); step();
        lookup(32'h40, 1'b0, 32'h0, 2'b00, "alias_evicted_40"); step();
        lookup(32'h80, 1'b1, 32'h200, 2'b01, "alias_hit_80"); step();
        // Tag mismatch on idx 1.
        update(32'h44, 32'h300, 2'b11); step();
        lookup(32'h84, 1'b0, 32'h0, 2'b00, "tag_miss_84"); step();
        lookup(32'h44, 1'b1, 32'h300, 2'b11, "hit_44"); step();
        chk("lookupcnt_run", 32'(LookupCnt), 32'd8);
        chk("hitcnt_run", 32'(HitCnt), 32'd5);

        // Clear concurrent with an update at 0x48; lookup that cycle still in RUN.
        update(32'h40, 32'h100, 2'b10); step();
        ClearReq = 1'b1;
        update(32'h48, 32'h480, 2'b10);
        lookup(32'h40, 1'b1, 32'h100, 2'b10, "hit_40_at_clear"); step();
        n = 0;
        while (Busy && n < 100) begin
            update(32'h4C, 32'h4C0, 2'b11);
            lookup(32'h80, 1'b0, 32'h0, 2'b00, "miss_during_sweep");
            ClearReq = (n == 5);
            step();
            n++;
        end
        chk("clear_sweep_cycles", 32'(n), 32'd16);
        chk("lookupcnt_after_clear", 32'(LookupCnt), 32'd9);
        chk("hitcnt_after_clear", 32'(HitCnt), 32'd6);
        lookup(32'h40, 1'b0, 32'h0, 2'b00, "cleared_40"); step();
        lookup(32'h48, 1'b0, 32'h0, 2'b00, "dropped_48"); step();
        lookup(32'h80, 1'b0, 32'h0, 2'b00, "cleared_80"); step();
        lookup(32'h4C, 1'b0, 32'h0, 2'b00, "dropped_4C"); step();
        chk("lookupcnt_post", 32'(LookupCnt), 32'd13);

        // Saturation.
        update(32'h40, 32'h100, 2'b10); step();
        for (int i = 0; i < 20; i++) begin
            lookup(32'h40, 1'b1, 32'h100, 2'b10, "sat_hit_40");
            step();
        end
        chk("lookupcnt_sat", 32'(LookupCnt), 32'hF);
        chk("hitcnt_sat", 32'(HitCnt), 32'hF);

        // Reset in the middle of a sweep.
        ClearReq = 1'b1; step();
        repeat (5) step();
        chk("midsweep_busy", 32'(Busy), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("midsweep_rst_lookupcnt", 32'(LookupCnt), 32'd0);
        chk("midsweep_rst_hitcnt", 32'(HitCnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (Busy && n < 100) begin step(); n++; end
        chk("resweep_cycles", 32'(n), 32'd16);
        lookup(32'h40, 1'b0, 32'h0, 2'b00, "after_reset_40"); step();
        chk("lookupcnt_after_reset", 32'(LookupCnt), 32'd1);
        chk("hitcnt_after_reset", 32'(HitCnt), 32'd0);

        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_ctrl.md
Name: btb_ctrl

Overview:
Direct-mapped branch target buffer and its controller for the 3-stage pipeline. The fetch stage looks up the current PC and receives the hit flag, predicted target and 2-bit predictor state consumed by branch_unit. branch_unit's write strobe, new counter state and resolved target update the table. An internal sweep FSM initialises or clears the table, and saturating statistics counters record lookups and hits.

Parameters:
PC_W, 32, PC and target width in bits.
IDX_W, 4, index width; table holds 2**IDX_W entries.
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
LookupValid  in  1  fetch PC valid this cycle.
LookupPc  in  PC_W  fetch PC.
PcMatchValid  out  1  hit: valid entry with matching tag.
PredTarget  out  PC_W  stored target on hit, 0 on miss.
CtrlIn  out  2  stored predictor state on hit, 2'b00 on miss.
WriteEnable  in  1  update strobe from branch_unit.
UpdPc  in  PC_W  PC of the resolved branch or jump.
UpdTarget  in  PC_W  resolved target.
CtrlOut  in  2  new predictor state from branch_unit.
ClearReq  in  1  single-cycle pulse requesting invalidation of the whole table.
Busy  out  1  sweep in progress.
LookupCnt  out  CNT_W  lookups accepted in RUN.
HitCnt  out  CNT_W  hits in RUN.

Behaviour:
- Indexing: idx = PC[IDX_W+1:2]; tag = PC[PC_W-1:IDX_W+2]. Each entry holds valid, tag, target[PC_W] and ctr[2].
- Lookup is combinational from the registered table: zero-cycle latency.
  - PcMatchValid = LookupValid & state==RUN & valid[idx] & tag match.
- FSM states are SWEEP and RUN.
  - Async reset: state=SWEEP, sweep pointer=0, Busy=1, LookupCnt=HitCnt=0. Combinational outputs are 0 because state is not RUN.
  - SWEEP: each cycle writes entry[ptr] with valid=0, ctr=2'b01, then increments ptr. On ptr == 2**IDX_W-1 the FSM goes to RUN next cycle. The sweep takes exactly 2**IDX_W cycles; Busy deasserts on the first RUN cycle.
  - RUN with ClearReq=1: go to SWEEP with ptr=0. The statistics counters are not cleared.
  - SWEEP with ClearReq=1: ignored; the sweep continues from its current ptr.
- Update in RUN with WriteEnable=1 writes entry[idx(UpdPc)] on the clock edge: valid=1, tag, target=UpdTarget, ctr=CtrlOut. Any previous occupant is overwritten.
- WriteEnable during SWEEP is dropped: no write and no stall.
- Same-cycle lookup and update to the same index: the lookup returns the old contents (no forwarding). The new contents are visible from the next cycle.
- ClearReq and WriteEnable in the same RUN cycle: the update is dropped and the sweep starts.
- Statistics, RUN only:
  - LookupCnt increments when LookupValid=1.
  - HitCnt increments when PcMatchValid=1.
  - Both saturate at all-ones and never wrap.
- Tag, target and ctr storage has no reset; it is defined only after the sweep. Only valid matters for correctness.
- Reset asserted mid-update or mid-sweep: immediate return to the reset state, and a fresh full sweep follows.

Decomposition:
- Shared package btb_pkg holds:
  - state encoding ST_SWEEP, ST_RUN;
  - CTR_WEAK_NT=2'b01 init constant;
  - the idx/tag slice functions, parameterised by IDX_W.
- One sub-module, btb_sat_cnt: CNT_W-bit saturating counter with inc input, async active-low reset. It is instantiated twice.

Test Plan:
- Reset then idle: Busy=1 for exactly 16 cycles. On cycle 17, Busy=0. A lookup of 0x0000_0040 gives PcMatchValid=0, CtrlIn=00, PredTarget=0.
- Update UpdPc=0x0000_0040, UpdTarget=0x0000_0100, CtrlOut=10. A lookup of 0x40 on the next cycle gives PcMatchValid=1, PredTarget=0x100, CtrlIn=10.
- Same-cycle update and lookup, both at 0x40, with CtrlOut=11 over a prior 10: that cycle shows CtrlIn=10, the next cycle shows 11.
- Aliasing:
  - Update 0x40 (idx 0), then update 0x80 with UpdTarget=0x200: the lookup of 0x40 misses and the lookup of 0x80 hits with target 0x200.
  - Update 0x44, then look up 0x84 (same idx 1, different tag): miss.
- ClearReq in RUN concurrent with WriteEnable at 0x48: Busy=1 for 16 cycles and updates issued during the sweep are dropped. Afterwards the lookups of 0x40 and 0x48 miss. LookupCnt retains its pre-clear value.
- Saturation with CNT_W=4: 20 consecutive hitting lookups give HitCnt=LookupCnt=4'hF. Assert rst_n low mid-sweep, then release: the counters read 0 and the sweep restarts at ptr 0, lasting 16 cycles.
